// File: rtl/toggle_gen_bank_pkg.sv
// Shared sizing helpers for the toggle generator bank and its benches.
package toggle_gen_bank_pkg;

   // Lane-index width, never narrower than one bit so a single-lane build still has a port.
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_CHANNELS = 4;
   localparam int CH_W         = ch_w(DEF_CHANNELS);

endpackage

// File: rtl/toggle_gen_bank_lane.sv
// One square-wave lane: programmable divider, phase toggle, output inversion, terminal-count tick.
module toggle_gen_lane #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             we,
   input  logic [WIDTH-1:0] wr_div,
   input  logic             wr_inv,
   output logic             wave,
   output logic             tick
);

   logic [WIDTH-1:0] cnt, div;
   logic             phase, inv;

   logic [WIDTH-1:0] cnt_nxt, div_nxt;
   logic             phase_nxt, inv_nxt, tick_nxt;

   // A write wins over a coincident terminal count: it reloads the lane and suppresses the toggle.
   always_comb begin
      cnt_nxt   = cnt;
      div_nxt   = div;
      phase_nxt = phase;
      inv_nxt   = inv;
      tick_nxt  = 1'b0;
      if (we) begin
         cnt_nxt = '0;
         div_nxt = wr_div;
         inv_nxt = wr_inv;
      end else if (en) begin
         if (cnt == div) begin
            cnt_nxt   = '0;
            phase_nxt = ~phase;
            tick_nxt  = 1'b1;
         end else begin
            cnt_nxt = cnt + WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         div   <= WIDTH'(DEFAULT_DIV);
         phase <= 1'b0;
         inv   <= 1'b0;
         wave  <= 1'b0;
         tick  <= 1'b0;
      end else begin
         cnt   <= cnt_nxt;
         div   <= div_nxt;
         phase <= phase_nxt;
         inv   <= inv_nxt;
         wave  <= phase_nxt ^ inv_nxt;
         tick  <= tick_nxt;
      end
   end

endmodule

// File: rtl/toggle_gen_bank.sv
// Bank of independent toggle lanes configured one at a time through a shared write port.
module toggle_gen_bank
   import toggle_gen_bank_pkg::*;
#(
   parameter int CHANNELS    = 4,
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [CHANNELS-1:0]         en,
   input  logic                        cfg_we,
   input  logic [ch_w(CHANNELS)-1:0]   cfg_ch,
   input  logic [WIDTH-1:0]            cfg_div,
   input  logic                        cfg_inv,
   output logic [CHANNELS-1:0]         wave,
   output logic [CHANNELS-1:0]         tick
);

   localparam int CW = ch_w(CHANNELS);

   logic [CHANNELS-1:0] we_lane;

   // Out-of-range indices match no lane, so such writes fall away naturally.
   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      assign we_lane[i] = cfg_we && (cfg_ch == CW'(i));

      toggle_gen_lane #(
         .WIDTH       (WIDTH),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_lane (
         .clk    (clk),
         .rst    (rst),
         .en     (en[i]),
         .we     (we_lane[i]),
         .wr_div (cfg_div),
         .wr_inv (cfg_inv),
         .wave   (wave[i]),
         .tick   (tick[i])
      );
   end

endmodule

// File: tb/tb_toggle_gen_bank.sv
// Directed self-checking bench for toggle_gen_bank (six-lane build to reach out-of-range indices).
module tb_toggle_gen_bank;
   import toggle_gen_bank_pkg::*;

   localparam int CHANNELS = 6;
   localparam int WIDTH    = 8;
   localparam int CW       = ch_w(CHANNELS);

   logic                clk = 1'b0;
   logic                rst;
   logic [CHANNELS-1:0] en;
   logic                cfg_we;
   logic [CW-1:0]       cfg_ch;
   logic [WIDTH-1:0]    cfg_div;
   logic                cfg_inv;
   logic [CHANNELS-1:0] wave, tick;

   int checks   = 0;
   int failures = 0;

   toggle_gen_bank #(.CHANNELS(CHANNELS), .WIDTH(WIDTH), .DEFAULT_DIV(0)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .cfg_we  (cfg_we),
      .cfg_ch  (cfg_ch),
      .cfg_div (cfg_div),
      .cfg_inv (cfg_inv),
      .wave    (wave),
      .tick    (tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [CW-1:0] ch, input logic [WIDTH-1:0] d, input logic inv);
      cfg_we  = 1'b1;
      cfg_ch  = ch;
      cfg_div = d;
      cfg_inv = inv;
   endtask

   initial begin
      rst = 1'b1; en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_inv = 1'b0;
      #2;
      chk("reset_wave", 32'(wave), 32'h0);
      chk("reset_tick", 32'(tick), 32'h0);
      step(); step();
      rst = 1'b0;
      en  = 6'b000001;

      // Test 1: default div=0 on lane 0 toggles every cycle
      for (int k = 1; k <= 4; k++) begin
         step();
         chk($sformatf("t1_wave_c%0d", k), 32'(wave), (k % 2 == 1) ? 32'h1 : 32'h0);
         chk($sformatf("t1_tick_c%0d", k), 32'(tick), 32'h1);
      end

      // Test 2: lane 1 div=3, period 8
      en = 6'b000010;
      wr(1, 8'd3, 1'b0);
      step();
      chk("t2_wr_wave", 32'(wave), 32'h0);
      chk("t2_wr_tick", 32'(tick), 32'h0);
      cfg_we = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         step();
         chk($sformatf("t2_wave1_c%0d", k), 32'(wave[1]), 32'((k / 4) % 2));
         chk($sformatf("t2_tick_c%0d", k), 32'(tick), (k % 4 == 0) ? 32'h2 : 32'h0);
         chk($sformatf("t2_wave0_c%0d", k), 32'(wave[0]), 32'h0);
      end

      // Test 3: freeze lane 1 at cnt=2
      step(); step();
      chk("t3_pre_wave", 32'(wave), 32'h0);
      en = '0;
      for (int k = 1; k <= 5; k++) begin
         step();
         chk($sformatf("t3_hold_wave_c%0d", k), 32'(wave), 32'h0);
         chk($sformatf("t3_hold_tick_c%0d", k), 32'(tick), 32'h0);
      end
      en = 6'b000010;
      step();
      chk("t3_re1_wave", 32'(wave), 32'h0);
      chk("t3_re1_tick", 32'(tick), 32'h0);
      step();
      chk("t3_re2_wave", 32'(wave), 32'h2);
      chk("t3_re2_tick", 32'(tick), 32'h2);

      // Test 4: invert disabled lane 2 while lane 1 keeps counting
      wr(2, 8'd0, 1'b1);
      step();
      chk("t4_wave", 32'(wave), 32'h6);
      chk("t4_tick", 32'(tick), 32'h0);
      cfg_we = 1'b0;
      step();
      chk("t4_hold_wave", 32'(wave), 32'h6);

      // Test 5: write lane 1 exactly at its terminal count
      step();
      chk("t5_cnt3_tick", 32'(tick), 32'h0);
      wr(1, 8'd1, 1'b0);
      step();
      chk("t5_wr_wave1", 32'(wave[1]), 32'h1);
      chk("t5_wr_tick", 32'(tick), 32'h0);
      cfg_we = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         step();
         chk($sformatf("t5_wave1_c%0d", k), 32'(wave[1]), (k == 1 || k == 4) ? 32'h1 : 32'h0);
         chk($sformatf("t5_tick_c%0d", k), 32'(tick), (k % 2 == 0) ? 32'h2 : 32'h0);
      end

      // Test 6a: out-of-range indices change nothing
      en = '0;
      wr(6, 8'd5, 1'b0);
      step();
      chk("t6_ch6_wave", 32'(wave), 32'h6);
      chk("t6_ch6_tick", 32'(tick), 32'h0);
      wr(7, 8'd5, 1'b1);
      step();
      chk("t6_ch7_wave", 32'(wave), 32'h6);
      cfg_we = 1'b0;
      en = 6'b001000;
      step();
      chk("t6_lane3_wave", 32'(wave), 32'hE);
      chk("t6_lane3_tick", 32'(tick), 32'h8);

      // Test 6b: asynchronous reset mid-count restores defaults
      en = 6'b001010;
      step();
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_wave", 32'(wave), 32'h0);
      chk("t6_rst_tick", 32'(tick), 32'h0);
      step();
      rst = 1'b0;
      en  = 6'b000010;
      step();
      chk("t6_post_wave_c1", 32'(wave), 32'h2);
      chk("t6_post_tick_c1", 32'(tick), 32'h2);
      step();
      chk("t6_post_wave_c2", 32'(wave), 32'h0);
      chk("t6_post_tick_c2", 32'(tick), 32'h2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
